fp_add: RTL and testbench

// - Multi-cycle IEEE-754 binary32 adder: a+b -> sum, round-to-nearest-even.
// - Start/done handshake; one operation in flight. Used as a shared FP add unit.

---
 rtl/fp_add.sv | 195 +++++++++++++++++++
 tb/tb_fp_add.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fp_add.sv
// Multi-cycle IEEE-754 binary32 adder with round-to-nearest-even and a start/done handshake.
// Optional macro FPADD_DAZ_EN: denormal inputs read as signed zero, denormal results flush to signed zero.
module fp_add (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum,
    output logic        done,
    output logic [2:0]  dbg_state
);

`ifdef FPADD_DAZ_EN
    localparam logic DAZ = 1'b1;
`else
    localparam logic DAZ = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
    } state_t;

    state_t      r_state, w_state_nx;
    logic [31:0] r_a, r_b, r_sum;
    logic        r_done, r_sa, r_sb, r_sign, r_sub;
    logic [7:0]  r_ea, r_eb;
    logic [26:0] r_ma, r_mb, r_mx, r_my;
    logic [8:0]  r_exp;

    // Operand classification (UNPACK)
    logic [7:0]  w_ea, w_eb;
    logic [22:0] w_fa, w_fb;
    logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic        w_special;
    logic [31:0] w_special_val;

    assign w_ea     = r_a[30:23];
    assign w_eb     = r_b[30:23];
    assign w_fa     = r_a[22:0];
    assign w_fb     = r_b[22:0];
    assign w_a_nan  = (w_ea == 8'hFF) && (w_fa != 23'd0);
    assign w_b_nan  = (w_eb == 8'hFF) && (w_fb != 23'd0);
    assign w_a_inf  = (w_ea == 8'hFF) && (w_fa == 23'd0);
    assign w_b_inf  = (w_eb == 8'hFF) && (w_fb == 23'd0);
    assign w_a_zero = (w_ea == 8'd0) && ((w_fa == 23'd0) || DAZ);
    assign w_b_zero = (w_eb == 8'd0) && ((w_fb == 23'd0) || DAZ);
    assign w_special = w_a_nan | w_b_nan | w_a_inf | w_b_inf | (w_a_zero & w_b_zero);

    always_comb begin
        w_special_val = {r_a[31] & r_b[31], 31'd0};
        if (w_a_nan || w_b_nan)
            w_special_val = 32'h7FC00000;
        else if (w_a_inf && w_b_inf && (r_a[31] != r_b[31]))
            w_special_val = 32'h7FC00000;
        else if (w_a_inf)
            w_special_val = {r_a[31], 8'hFF, 23'd0};
        else if (w_b_inf)
            w_special_val = {r_b[31], 8'hFF, 23'd0};
    end

    // Alignment: the larger magnitude stays put, the smaller is shifted with sticky collection
    logic        w_a_big;
    logic [7:0]  w_e_big, w_e_sml, w_diff;
    logic [26:0] w_m_big, w_m_sml, w_shifted, w_mask, w_m_aln;
    logic        w_lost;

    assign w_a_big   = {r_ea, r_ma} >= {r_eb, r_mb};
    assign w_e_big   = w_a_big ? r_ea : r_eb;
    assign w_e_sml   = w_a_big ? r_eb : r_ea;
    assign w_m_big   = w_a_big ? r_ma : r_mb;
    assign w_m_sml   = w_a_big ? r_mb : r_ma;
    assign w_diff    = w_e_big - w_e_sml;
    assign w_shifted = w_m_sml >> w_diff;
    assign w_mask    = ~(27'h7FFFFFF << w_diff);
    assign w_lost    = |(w_m_sml & w_mask);
    assign w_m_aln   = (w_diff >= 8'd27) ? {26'd0, |w_m_sml}
                                         : {w_shifted[26:1], w_shifted[0] | w_lost};

    logic [27:0] w_sum28;
    logic        w_add_zero;
    assign w_sum28    = r_sub ? ({1'b0, r_mx} - {1'b0, r_my}) : ({1'b0, r_mx} + {1'b0, r_my});
    assign w_add_zero = (w_sum28 == 28'd0);

    logic w_norm_stop, w_norm_flush;
    assign w_norm_stop  = r_mx[26] || (r_exp == 9'd1);
    assign w_norm_flush = DAZ && w_norm_stop && !r_mx[26];

    // Rounding: mantissa is hidden|frac[22:0]|G|R|S
    logic        w_inc;
    logic [24:0] w_rnd;
    logic [23:0] w_rmant;
    logic [8:0]  w_rexp;
    logic [31:0] w_result;

    assign w_inc    = r_mx[2] & (r_mx[1] | r_mx[0] | r_mx[3]);
    assign w_rnd    = {1'b0, r_mx[26:3]} + {24'd0, w_inc};
    assign w_rexp   = r_exp + {8'd0, w_rnd[24]};
    assign w_rmant  = w_rnd[24] ? w_rnd[24:1] : w_rnd[23:0];
    assign w_result = (w_rexp >= 9'd255) ? {r_sign, 8'hFF, 23'd0}
                    : {r_sign, (w_rmant[23] ? w_rexp[7:0] : 8'h00), w_rmant[22:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start) w_state_nx = S_UNPACK;
            S_UNPACK:       w_state_nx = w_special ? S_DONE : S_ALIGN;
            S_ALIGN:        w_state_nx = S_ADD;
            S_ADD:          w_state_nx = w_add_zero ? S_DONE : S_NORM;
            S_NORM: begin
                if (w_norm_flush)     w_state_nx = S_DONE;
                else if (w_norm_stop) w_state_nx = S_ROUND;
            end
            S_ROUND:        w_state_nx = S_DONE;
            default:        w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_done <= 1'b0;
            r_sum  <= 32'd0;
            r_a    <= 32'd0;
            r_b    <= 32'd0;
            r_sa   <= 1'b0;
            r_sb   <= 1'b0;
            r_ea   <= 8'd0;
            r_eb   <= 8'd0;
            r_ma   <= 27'd0;
            r_mb   <= 27'd0;
            r_mx   <= 27'd0;
            r_my   <= 27'd0;
            r_exp  <= 9'd0;
            r_sign <= 1'b0;
            r_sub  <= 1'b0;
        end else begin
            r_done <= (w_state_nx == S_DONE);
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_a <= a;
                        r_b <= b;
                    end
                end
                S_UNPACK: begin
                    if (w_special) r_sum <= w_special_val;
                    r_sa <= r_a[31];
                    r_sb <= r_b[31];
                    r_ea <= (w_ea == 8'd0) ? 8'd1 : w_ea;
                    r_eb <= (w_eb == 8'd0) ? 8'd1 : w_eb;
                    r_ma <= w_a_zero ? 27'd0 : {(w_ea != 8'd0), w_fa, 3'b000};
                    r_mb <= w_b_zero ? 27'd0 : {(w_eb != 8'd0), w_fb, 3'b000};
                end
                S_ALIGN: begin
                    r_mx   <= w_m_big;
                    r_my   <= w_m_aln;
                    r_exp  <= {1'b0, w_e_big};
                    r_sign <= w_a_big ? r_sa : r_sb;
                    r_sub  <= r_sa ^ r_sb;
                end
                S_ADD: begin
                    // Exact cancellation always yields +0; both-zero cases never get here
                    if (w_add_zero) begin
                        r_sum <= 32'd0;
                    end else if (w_sum28[27]) begin
                        r_mx  <= {w_sum28[27:2], w_sum28[1] | w_sum28[0]};
                        r_exp <= r_exp + 9'd1;
                    end else begin
                        r_mx <= w_sum28[26:0];
                    end
                end
                S_NORM: begin
                    if (w_norm_flush) begin
                        r_sum <= {r_sign, 31'd0};
                    end else if (!w_norm_stop) begin
                        r_mx  <= {r_mx[25:0], 1'b0};
                        r_exp <= r_exp - 9'd1;
                    end
                end
                S_ROUND: r_sum <= w_result;
                default: ;
            endcase
        end
    end

    assign sum       = r_sum;
    assign done      = r_done;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_fp_add.sv
// Self-checking bench for fp_add: vector table through a scoreboard queue, plus reset-abort
// and busy-start sequences. Expected values follow FPADD_DAZ_EN when it is defined.
module tb_fp_add;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] a, b;
    logic [31:0] sum;
    logic        done;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          special;
    } vec_t;

    vec_t vecs[20];

`ifdef FPADD_DAZ_EN
    localparam logic [31:0] EXP_DEN_ADD = 32'h00000000;
    localparam logic [31:0] EXP_DEN_SUB = 32'h00800000;
    localparam bit          DEN_SPECIAL = 1'b1;
`else
    localparam logic [31:0] EXP_DEN_ADD = 32'h00000002;
    localparam logic [31:0] EXP_DEN_SUB = 32'h007FFFFF;
    localparam bit          DEN_SPECIAL = 1'b0;
`endif

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    fp_add dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .b         (b),
        .sum       (sum),
        .done      (done),
        .dbg_state (dbg_state)
    );

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", nm, act, req);
        end
    endtask

    // driver: one-cycle start pulse, expectation pushed to the scoreboard
    task automatic drive_op(input logic [31:0] ia, input logic [31:0] ib,
                            input logic [31:0] iexp, input string nm);
        @(negedge clk);
        a     = ia;
        b     = ib;
        start = 1'b1;
        exp_q.push_back(iexp);
        name_q.push_back(nm);
        @(negedge clk);
        start = 1'b0;
    endtask

    // scoreboard: wait for done (bounded), pop and compare; lat = edges from start to done
    task automatic wait_result(output int lat);
        logic [31:0] e;
        string       nm;
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_timeout: done=%0b after %0d cycles, required done=1", nm, done, lat);
        end else begin
            check32(nm, sum, e);
        end
    endtask

    initial begin
        int lat;

        vecs[0]  = '{32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0};
        vecs[1]  = '{32'h40400000, 32'hBF800000, 32'h40000000, 1'b0};
        vecs[2]  = '{32'h3F800000, 32'hBF800000, 32'h00000000, 1'b0};
        vecs[3]  = '{32'h3F800000, 32'h33800000, 32'h3F800000, 1'b0};
        vecs[4]  = '{32'h3F800001, 32'h33800000, 32'h3F800002, 1'b0};
        vecs[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b0};
        vecs[6]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b1};
        vecs[7]  = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 1'b1};
        vecs[8]  = '{32'h00000001, 32'h00000001, EXP_DEN_ADD,  DEN_SPECIAL};
        vecs[9]  = '{32'hFF800000, 32'h3F800000, 32'hFF800000, 1'b1};
        vecs[10] = '{32'h80000000, 32'h80000000, 32'h80000000, 1'b1};
        vecs[11] = '{32'h80000000, 32'h00000000, 32'h00000000, 1'b1};
        vecs[12] = '{32'h3F800000, 32'h00000000, 32'h3F800000, 1'b0};
        vecs[13] = '{32'hC0000000, 32'h3F800000, 32'hBF800000, 1'b0};
        vecs[14] = '{32'h3FC00000, 32'h3FC00000, 32'h40400000, 1'b0};
        vecs[15] = '{32'h00800000, 32'h80000001, EXP_DEN_SUB,  1'b0};
        vecs[16] = '{32'h3F800000, 32'h33800001, 32'h3F800001, 1'b0};
        vecs[17] = '{32'h3F7FFFFF, 32'h33800000, 32'h3F800000, 1'b0};
        vecs[18] = '{32'h3F7FFFFF, 32'h33000000, 32'h3F800000, 1'b0};
        vecs[19] = '{32'h7F7FFFFF, 32'h73000000, 32'h7F800000, 1'b0};

        reset = 1'b0;
        start = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        repeat (3) @(negedge clk);
        check32("reset_sum", sum, 32'd0);
        check32("reset_done", {31'd0, done}, 32'd0);
        check32("reset_state", {29'd0, dbg_state}, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 20; i++) begin
            drive_op(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
            wait_result(lat);
            n_checks++;
            if (vecs[i].special ? (lat != 2) : (lat > 36)) begin
                n_fail++;
                $display("FAIL vec%0d_latency: got %0d cycles, required %s", i, lat,
                         vecs[i].special ? "2" : "<= 36");
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // start pulsed while busy must be ignored
        drive_op(32'h40400000, 32'hBF800000, 32'h40000000, "busy_start");
        a     = 32'h3F800000;
        b     = 32'h3F800000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_result(lat);
        repeat (2) @(negedge clk);
        check32("done_held", {31'd0, done}, 32'd1);
        check32("sum_held", sum, 32'h40000000);

        // reset mid-operation aborts and clears outputs immediately
        drive_op(32'h3FC00000, 32'h3FC00000, 32'h40400000, "aborted");
        @(negedge clk);
        reset = 1'b0;
        #1;
        exp_q.delete();
        name_q.delete();
        check32("abort_sum", sum, 32'd0);
        check32("abort_done", {31'd0, done}, 32'd0);
        check32("abort_state", {29'd0, dbg_state}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        drive_op(32'h3FC00000, 32'h3FC00000, 32'h40400000, "after_reset");
        wait_result(lat);

        // back-to-back start from DONE drops done on the next cycle
        drive_op(32'hC0000000, 32'h3F800000, 32'hBF800000, "from_done");
        check32("done_dropped", {31'd0, done}, 32'd0);
        wait_result(lat);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
